// File: rtl/l0_loader.sv
// Streams num_vec consecutive activation vectors from SRAM into the L0 buffer.
// A 2-entry holding buffer absorbs the 1-cycle SRAM latency under L0 back-pressure.
module l0_loader #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11,
    parameter int cnt_w  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [cnt_w-1:0]    num_vec,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [addr_w-1:0]   sram_addr,
    input  logic [row*bw-1:0]   sram_q,
    input  logic                l0_ready,
    output logic                l0_wr,
    output logic [row*bw-1:0]   l0_in,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [addr_w-1:0]   addr_q, addr_d;
    logic [cnt_w-1:0]    rem_q, rem_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [row*bw-1:0]   buf0_q, buf0_d;
    logic [row*bw-1:0]   buf1_q, buf1_d;

    logic [2:0]          occ;
    logic                issue;
    logic                push;

    // Occupancy counts the read in flight so that it always has a slot to land in.
    always_comb begin
        l0_wr = (cnt_q != 2'd0) && l0_ready;
        occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, l0_wr};
        issue = (state_q == FETCH) && (rem_q != '0) && (occ < 3'd2);
        push  = inflight_q;
    end

    assign sram_cen  = ~issue;
    assign sram_wen  = 1'b1;
    assign sram_addr = addr_q;
    assign l0_in     = buf0_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        cnt_d      = cnt_q;
        inflight_d = issue;

        unique case ({push, l0_wr})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = sram_q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = sram_q;
                end
            end
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = sram_q;
                else               buf1_d = sram_q;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            default: ;
        endcase

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = num_vec;
                    state_d = (num_vec != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d = addr_q + addr_w'(1);
                    rem_d  = rem_q - cnt_w'(1);
                    if (rem_q == cnt_w'(1)) state_d = DRAIN;
                end
            end
            // Leave as the last vector is popped so done follows the final write directly.
            DRAIN: begin
                if (cnt_d == 2'd0 && !inflight_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_l0_loader.sv
// Directed bench for l0_loader with a behavioural 1-cycle-latency SRAM whose
// contents are a fixed function of the address.
module tb_l0_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [10:0] num_vec;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_q;
    logic        l0_ready;
    logic        l0_wr;
    logic [31:0] l0_in;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    l0_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_vec(num_vec), .sram_cen(sram_cen), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_q(sram_q), .l0_ready(l0_ready),
        .l0_wr(l0_wr), .l0_in(l0_in), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [10:0] a);
        return {~a[7:0], 5'b00000, a, 8'h3C};
    endfunction

    // Read data appears the cycle after issue; otherwise a poison value.
    always @(posedge clk) begin
        if (!sram_cen && sram_wen) sram_q <= pattern(sram_addr);
        else                       sram_q <= 32'hDEADBEEF;
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; l0_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("[TB] FAIL reset_cen got %b want 1", sram_cen); end
        checks++; if (sram_wen !== 1'b1) begin errors++; $display("[TB] FAIL reset_wen got %b want 1", sram_wen); end
        checks++; if (sram_addr !== 11'h000) begin errors++; $display("[TB] FAIL reset_addr got %h want 000", sram_addr); end
        checks++; if (l0_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr got %b want 0", l0_wr); end
        checks++; if (l0_in !== 32'h0) begin errors++; $display("[TB] FAIL reset_l0_in got %h want 0", l0_in); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done got %b%b want 00", busy, done); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic(input logic [10:0] base, input logic [10:0] num,
                              input logic [15:0] rd_mask, input logic [15:0] wr_mask,
                              input int done_c, input logic [15:0] stall_mask, input string tag);
        int rd_k = 0;
        int wr_k = 0;
        logic [10:0] exp_addr;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_vec = num; l0_ready = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || sram_cen !== 1'b1) begin errors++; $display("[TB] FAIL %s_c0 busy/cen got %b%b want 01", tag, busy, sram_cen); end
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            start = 1'b0; l0_ready = ~stall_mask[c];
            @(negedge clk);
            checks++; if (sram_cen !== ~rd_mask[c]) begin errors++; $display("[TB] FAIL %s_cen cycle %0d got %b want %b", tag, c, sram_cen, ~rd_mask[c]); end
            if (rd_mask[c]) begin
                exp_addr = base + 11'(rd_k);
                checks++; if (sram_addr !== exp_addr) begin errors++; $display("[TB] FAIL %s_addr cycle %0d got %h want %h", tag, c, sram_addr, exp_addr); end
                rd_k++;
            end
            checks++; if (l0_wr !== wr_mask[c]) begin errors++; $display("[TB] FAIL %s_wr cycle %0d got %b want %b", tag, c, l0_wr, wr_mask[c]); end
            if (wr_mask[c]) begin
                checks++; if (l0_in !== pattern(base + 11'(wr_k))) begin errors++; $display("[TB] FAIL %s_data cycle %0d got %h want %h", tag, c, l0_in, pattern(base + 11'(wr_k))); end
                wr_k++;
            end
            checks++; if (done !== (c == done_c)) begin errors++; $display("[TB] FAIL %s_done cycle %0d got %b want %b", tag, c, done, (c == done_c)); end
            checks++; if (busy !== (c <= done_c)) begin errors++; $display("[TB] FAIL %s_busy cycle %0d got %b want %b", tag, c, busy, (c <= done_c)); end
        end
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        int k = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'h7FE; num_vec = 11'd4; l0_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (c <= 4) begin
                checks++; if (sram_cen !== 1'b0 || sram_addr !== exp_a[k]) begin errors++; $display("[TB] FAIL wrap_addr cycle %0d got cen=%b addr=%h want cen=0 addr=%h", c, sram_cen, sram_addr, exp_a[k]); end
                k++;
            end
            if (c >= 3 && c <= 6) begin
                checks++; if (l0_wr !== 1'b1 || l0_in !== pattern(exp_a[c-3])) begin errors++; $display("[TB] FAIL wrap_data cycle %0d got wr=%b %h want wr=1 %h", c, l0_wr, l0_in, pattern(exp_a[c-3])); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done got %b want 1", done); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_zero_len();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'h123; num_vec = 11'd0; l0_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            checks++; if (sram_cen !== 1'b1 || l0_wr !== 1'b0) begin errors++; $display("[TB] FAIL zero_quiet cycle %0d got cen=%b wr=%b want cen=1 wr=0", c, sram_cen, l0_wr); end
            checks++; if (busy !== (c == 1) || done !== (c == 1)) begin errors++; $display("[TB] FAIL zero_busy_done cycle %0d got %b%b want %b%b", c, busy, done, (c == 1), (c == 1)); end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'h020; num_vec = 11'd8; l0_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (sram_cen !== 1'b1 || sram_addr !== 11'h000) begin errors++; $display("[TB] FAIL midrst_sram got cen=%b addr=%h want cen=1 addr=000", sram_cen, sram_addr); end
        checks++; if (l0_wr !== 1'b0 || l0_in !== 32'h0) begin errors++; $display("[TB] FAIL midrst_l0 got wr=%b %h want wr=0 0", l0_wr, l0_in); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_done got %b%b want 00", busy, done); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (l0_wr !== 1'b0 || l0_in !== 32'h0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_late_q got wr=%b %h done=%b want wr=0 0 done=0", l0_wr, l0_in, done); end
        test_basic(11'h040, 11'd8, 16'h01FE, 16'h07F8, 11, 16'h0000, "restart");
    endtask

    task automatic test_back_to_back();
        int wr_k = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'h050; num_vec = 11'd3; l0_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = (c == 2 || c == 6);
            base_addr = 11'h300; num_vec = 11'd5;
            @(negedge clk);
            checks++; if (sram_cen !== !(c >= 1 && c <= 3)) begin errors++; $display("[TB] FAIL busystart_cen cycle %0d got %b want %b", c, sram_cen, !(c <= 3)); end
            if (c <= 3) begin
                checks++; if (sram_addr !== 11'h050 + 11'(c - 1)) begin errors++; $display("[TB] FAIL busystart_addr cycle %0d got %h want %h", c, sram_addr, 11'h050 + 11'(c - 1)); end
            end
            checks++; if (l0_wr !== (c >= 3 && c <= 5)) begin errors++; $display("[TB] FAIL busystart_wr cycle %0d got %b want %b", c, l0_wr, (c >= 3 && c <= 5)); end
            if (c >= 3 && c <= 5) begin
                checks++; if (l0_in !== pattern(11'h050 + 11'(wr_k))) begin errors++; $display("[TB] FAIL busystart_data cycle %0d got %h want %h", c, l0_in, pattern(11'h050 + 11'(wr_k))); end
                wr_k++;
            end
            checks++; if (busy !== (c <= 6) || done !== (c == 6)) begin errors++; $display("[TB] FAIL busystart_busy_done cycle %0d got %b%b want %b%b", c, busy, done, (c <= 6), (c == 6)); end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic(11'h010, 11'd4, 16'h001E, 16'h0078, 7, 16'h0000, "basic");
        test_basic(11'h100, 11'd6, 16'h0E0E, 16'h3E08, 14, 16'h01F0, "stall");
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
